// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// div_pkg : shared FSM state encoding and sizing constants for the divider.
// Rev 1.0
// ============================================================================
package div_pkg;

    localparam int NREQ          = 2;
    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/div_iter_core.sv
`default_nettype none
// ============================================================================
// div_iter_core : restoring shift-subtract datapath, one quotient bit per step.
// Rev 1.0
// ============================================================================
module div_iter_core
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             load_i,
    input  logic             fast_dz_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             last_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q,  rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] div_q,  div_d;
    logic [CW-1:0]    cnt_q,  cnt_d;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic             w_unused;

    // quot_q doubles as the dividend shift register: its MSB feeds the
    // partial remainder while quotient bits enter from the LSB side.
    always_comb begin
        w_trial = {rem_q, quot_q[WIDTH-1]};
        w_diff  = w_trial - {1'b0, div_q};
        w_ge    = (w_trial >= {1'b0, div_q});
        rem_d   = rem_q;
        quot_d  = quot_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            div_d = divisor_i;
            cnt_d = '0;
            if (fast_dz_i) begin
                quot_d = '1;
                rem_d  = dividend_i;
            end else begin
                quot_d = dividend_i;
                rem_d  = '0;
            end
        end else if (step_i) begin
            rem_d  = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], w_ge};
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // A restored remainder is always below the divisor, so the top bit is 0.
    assign w_unused = ^{w_diff[WIDTH], w_trial[WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quot_q <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
        end else if (ena) begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;
    assign last_o = step_i && (cnt_q == CW'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/div_rr_scheduler.sv
`default_nettype none
// ============================================================================
// div_rr_scheduler : two-requester round-robin front end to an iterative divider.
// Define DIV_ZERO_FAST_EN to retire divide-by-zero without iterating. Rev 1.0
// ============================================================================
module div_rr_scheduler
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [WIDTH-1:0]      rsp_quot,
    output logic [WIDTH-1:0]      rsp_rem,
    output logic                  rsp_dz,
    output logic                  busy
);

    state_t           state_q, state_d;
    logic             ptr_q,   ptr_d;
    logic             id_q,    id_d;
    logic             dz_q,    dz_d;

    logic             w_any;
    logic             w_gnt_id;
    logic             w_accept;
    logic             w_fast_dz;
    logic             w_last;
    logic [WIDTH-1:0] w_sel_dividend;
    logic [WIDTH-1:0] w_sel_divisor;

    // ptr_q names the requester that wins a tie.
    assign w_any          = |req_valid;
    assign w_gnt_id       = (&req_valid) ? ptr_q : req_valid[1];
    assign w_sel_dividend = req_dividend[int'(w_gnt_id)*WIDTH +: WIDTH];
    assign w_sel_divisor  = req_divisor[int'(w_gnt_id)*WIDTH +: WIDTH];

`ifdef DIV_ZERO_FAST_EN
    assign w_fast_dz = (w_sel_divisor == '0);
`else
    assign w_fast_dz = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = w_accept ? ~w_gnt_id : ptr_q;
        id_d    = w_accept ? w_gnt_id : id_q;
        dz_d    = w_accept ? (w_sel_divisor == '0) : dz_q;
        case (state_q)
            ST_IDLE: if (w_accept)  state_d = w_fast_dz ? ST_DONE : ST_CALC;
            ST_CALC: if (w_last)    state_d = ST_DONE;
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = (state_q != ST_IDLE);
        rsp_valid = (state_q == ST_DONE);
        if (rst_n && ena && (state_q == ST_IDLE) && w_any) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    assign w_accept = |req_ready;
    assign rsp_id   = id_q;
    assign rsp_dz   = dz_q;

    div_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .load_i     (w_accept),
        .fast_dz_i  (w_fast_dz),
        .step_i     (state_q == ST_CALC),
        .dividend_i (w_sel_dividend),
        .divisor_i  (w_sel_divisor),
        .quot_o     (rsp_quot),
        .rem_o      (rsp_rem),
        .last_o     (w_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_div_rr_scheduler.sv
`default_nettype none
// ============================================================================
// tb_div_rr_scheduler : vector table plus directed corner sequences, WIDTH=4.
// Rev 1.0
// ============================================================================
module tb_div_rr_scheduler;

    localparam int W = 4;
`ifdef DIV_ZERO_FAST_EN
    // the fast path presents the result right after the accepting edge itself
    localparam int DZ_LAT = 0;
`else
    localparam int DZ_LAT = W;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena = 1'b1;
    logic [1:0]     req_valid = '0;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_dividend = '0;
    logic [2*W-1:0] req_divisor = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic           rsp_id;
    logic [W-1:0]   rsp_quot;
    logic [W-1:0]   rsp_rem;
    logic           rsp_dz;
    logic           busy;

    always #5 clk = ~clk;

    div_rr_scheduler #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_quot     (rsp_quot),
        .rsp_rem      (rsp_rem),
        .rsp_dz       (rsp_dz),
        .busy         (busy)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ena && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_id",   int'(rsp_id),   int'(e.id));
                chk("rsp_quot", int'(rsp_quot), int'(e.q));
                chk("rsp_rem",  int'(rsp_rem),  int'(e.r));
                chk("rsp_dz",   int'(rsp_dz),   int'(e.dz));
            end
        end
    end

    task automatic push_exp(input int id, input logic [W-1:0] q, input logic [W-1:0] r,
                            input logic dz);
        exp_t e;
        e.id = 1'(id);
        e.q  = q;
        e.r  = r;
        e.dz = dz;
        sb_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic accept(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                          output int waited);
        req_dividend[id*W +: W] = a;
        req_divisor[id*W +: W]  = b;
        req_valid[id]           = 1'b1;
        #1;
        waited = 0;
        while (!req_ready[id] && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!req_ready[id]) begin
            chk("accept_timeout", 0, 1);
        end else begin
            push_exp(id, q, r, dz);
            @(posedge clk);
            #1;
        end
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[10];
        int   w;
        int   lat;

        tv[0] = '{0, 4'd10, 4'd3,  4'd3,  4'd1, 1'b0};
        tv[1] = '{1, 4'd5,  4'd0,  4'd15, 4'd5, 1'b1};
        tv[2] = '{0, 4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
        tv[3] = '{1, 4'd0,  4'd7,  4'd0,  4'd0, 1'b0};
        tv[4] = '{0, 4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
        tv[5] = '{1, 4'd3,  4'd7,  4'd0,  4'd3, 1'b0};
        tv[6] = '{0, 4'd0,  4'd0,  4'd15, 4'd0, 1'b1};
        tv[7] = '{1, 4'd14, 4'd4,  4'd3,  4'd2, 1'b0};
        tv[8] = '{0, 4'd12, 4'd5,  4'd2,  4'd2, 1'b0};
        tv[9] = '{1, 4'd15, 4'd2,  4'd7,  4'd1, 1'b0};

        // Reset state, with requests pending so req_ready gating is exercised.
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_rsp_quot",  int'(rsp_quot),  0);
        chk("rst_rsp_rem",   int'(rsp_rem),   0);
        chk("rst_rsp_id",    int'(rsp_id),    0);
        chk("rst_rsp_dz",    int'(rsp_dz),    0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Simultaneous requests: id0 first out of reset, then id1.
        req_dividend = {4'd9, 4'd15};
        req_divisor  = {4'd2, 4'd5};
        req_valid    = 2'b11;
        #1;
        chk("pair1_grant", int'(req_ready), 1);
        push_exp(0, 4'd3, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        chk("pair1_busy", int'(busy), 1);
        accept(1, 4'd9, 4'd2, 4'd4, 4'd1, 1'b0, w);
        chk("pair1_gap", w, W + 1);
        drain();

        // Last grant was id1, so the next tie goes to id0.
        req_valid = 2'b11;
        #1;
        chk("pair2_grant", int'(req_ready), 1);
        push_exp(0, 4'd3, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        accept(1, 4'd9, 4'd2, 4'd4, 4'd1, 1'b0, w);
        drain();

        for (int i = 0; i < 10; i++) begin
            accept(tv[i].id, tv[i].a, tv[i].b, tv[i].q, tv[i].r, tv[i].dz, w);
            wait_rsp(lat);
            chk($sformatf("lat_v%0d", i), lat, tv[i].dz ? DZ_LAT : W);
            drain();
        end

        // Back-pressure: result must hold and no new request is taken.
        rsp_ready = 1'b0;
        accept(0, 4'd7, 4'd3, 4'd2, 4'd1, 1'b0, w);
        wait_rsp(lat);
        chk("hold_lat", lat, W);
        req_dividend[W +: W] = 4'd8;
        req_divisor[W +: W]  = 4'd4;
        req_valid[1]         = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", int'(rsp_valid), 1);
            chk("hold_quot",  int'(rsp_quot),  2);
            chk("hold_rem",   int'(rsp_rem),   1);
            chk("hold_ready", int'(req_ready), 0);
        end
        chk("hold_sb", sb_q.size(), 1);
        rsp_ready = 1'b1;
        accept(1, 4'd8, 4'd4, 4'd2, 4'd0, 1'b0, w);
        chk("post_hs_wait", w, 1);
        wait_rsp(lat);
        drain();

        // Async reset in the second CALC cycle drops the operation.
        accept(0, 4'd10, 4'd3, 4'd3, 4'd1, 1'b0, w);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", int'(rsp_valid), 0);
        chk("midrst_busy",      int'(busy),      0);
        chk("midrst_quot",      int'(rsp_quot),  0);
        chk("midrst_rem",       int'(rsp_rem),   0);
        chk("midrst_id",        int'(rsp_id),    0);
        chk("midrst_dz",        int'(rsp_dz),    0);
        chk("midrst_ready",     int'(req_ready), 0);
        req_valid = 2'b00;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        accept(1, 4'd9, 4'd2, 4'd4, 4'd1, 1'b0, w);
        wait_rsp(lat);
        chk("postrst_lat", lat, W);
        drain();

        // ena low in IDLE blocks acceptance.
        ena = 1'b0;
        req_valid[1] = 1'b1;
        #1;
        chk("ena_idle_ready", int'(req_ready), 0);
        req_valid = 2'b00;
        ena = 1'b1;
        @(posedge clk);
        #1;

        // ena low for two edges mid-CALC stretches latency by two.
        accept(0, 4'd13, 4'd4, 4'd3, 4'd1, 1'b0, w);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) ena = 1'b0;
            if (lat == 2) chk("ena_busy", int'(busy), 1);
            if (lat == 3) ena = 1'b1;
        end
        chk("ena_lat", lat, W + 2);
        drain();

        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
